// File: rtl/mcb_port_emu_pkg.sv
// Shared definitions for the MCB user-port emulator: instruction encodings,
// FIFO geometry, FIFO entry layouts and the engine state type.
package mcb_port_emu_pkg;

  localparam logic [2:0] INSTR_WRITE    = 3'b000;
  localparam logic [2:0] INSTR_READ     = 3'b001;
  localparam logic [2:0] INSTR_WRITE_AP = 3'b010;
  localparam logic [2:0] INSTR_READ_AP  = 3'b011;
  localparam logic [2:0] INSTR_REFRESH  = 3'b100;

  localparam int MCB_CMD_DEPTH  = 4;
  localparam int MCB_DATA_DEPTH = 64;
  localparam int MCB_MAX_BL     = 63;
  localparam int REF_CYCLES     = 4;

  typedef struct packed {
    logic [1:0]  rsvd;
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] byte_addr;
  } cmd_t;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_beat_t;

  localparam int CMD_W = $bits(cmd_t);
  localparam int WR_W  = $bits(wr_beat_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_REF,
    ST_WBURST,
    ST_RBURST
  } state_t;

  // Any 1xx encoding is a refresh.
  function automatic state_t decode_state(input logic [2:0] instr);
    case (instr)
      INSTR_WRITE, INSTR_WRITE_AP: return ST_WBURST;
      INSTR_READ, INSTR_READ_AP:   return ST_RBURST;
      default:                     return ST_REF;
    endcase
  endfunction

endpackage

// File: rtl/mcb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two; dout reads 0 while empty.
module mcb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage arrays are not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mcb_port_emu.sv
// Spartan-6 MCB user-port responder backed by on-chip RAM.
// Define MCB_EMU_ERR_EN to make wr_underrun/wr_error/rd_overflow/rd_error live sticky flags.
module mcb_port_emu
  import mcb_port_emu_pkg::*;
#(
  parameter int MEM_ADDR_W   = 8,
  parameter int CALIB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        calib_done,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [29:0] cmd_byte_addr,
  output logic        cmd_empty,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [3:0]  wr_mask,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  output logic        wr_underrun,
  output logic        wr_error,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        rd_overflow,
  output logic        rd_error
);

  localparam int MEM_WORDS = 2 ** MEM_ADDR_W;

  logic [15:0] calib_cnt_q;
  logic        calib_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_cnt_q  <= '0;
      calib_done_q <= 1'b0;
    end else if (!calib_done_q) begin
      calib_cnt_q <= calib_cnt_q + 16'd1;
      if (calib_cnt_q == 16'(CALIB_CYCLES - 1)) calib_done_q <= 1'b1;
    end
  end
  assign calib_done = calib_done_q;

  cmd_t     cmd_in, cmd_head;
  wr_beat_t wr_in, wr_head;
  logic     cmd_pop, wr_pop;
  logic [2:0] cmd_count;

  assign cmd_in = '{rsvd: 2'b00, instr: cmd_instr, bl: cmd_bl, byte_addr: cmd_byte_addr};
  assign wr_in  = '{mask: wr_mask, data: wr_data};

  mcb_sync_fifo #(.WIDTH(CMD_W), .DEPTH(MCB_CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(cmd_en), .din_i(cmd_in), .pop_i(cmd_pop),
    .dout_o(cmd_head), .full_o(cmd_full), .empty_o(cmd_empty), .count_o(cmd_count)
  );

  mcb_sync_fifo #(.WIDTH(WR_W), .DEPTH(MCB_DATA_DEPTH)) u_wr_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(wr_en), .din_i(wr_in), .pop_i(wr_pop),
    .dout_o(wr_head), .full_o(wr_full), .empty_o(wr_empty), .count_o(wr_count)
  );

  // Engine state.
  state_t                state_q, state_d;
  logic [2:0]            instr_q, instr_d;
  logic [5:0]            beats_q, beats_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           last_wdata_q, last_wdata_d;
  logic                  ram_we, ram_re, rd_valid_q;
  logic [31:0]           ram_wdata, ram_rdata_q;
  logic [3:0]            ram_wmask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      beats_q      <= '0;
      addr_q       <= '0;
      last_wdata_q <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      beats_q      <= beats_d;
      addr_q       <= addr_d;
      last_wdata_q <= last_wdata_d;
      rd_valid_q   <= ram_re;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    beats_d      = beats_q;
    addr_d       = addr_q;
    last_wdata_d = last_wdata_q;
    cmd_pop      = 1'b0;
    wr_pop       = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_wdata    = last_wdata_q;
    ram_wmask    = 4'h0;
    case (state_q)
      ST_IDLE: begin
        if (calib_done_q && !cmd_empty) begin
          cmd_pop = 1'b1;
          instr_d = cmd_head.instr;
          beats_d = cmd_head.bl;
          addr_d  = cmd_head.byte_addr[MEM_ADDR_W+1:2];
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = decode_state(instr_q);
        if (instr_q[2]) beats_d = 6'(REF_CYCLES - 1);
      end
      ST_REF: begin
        beats_d = beats_q - 6'd1;
        if (beats_q == '0) state_d = ST_IDLE;
      end
      ST_WBURST: begin
        // An empty write FIFO does not stall: the last popped word is rewritten unmasked.
        ram_we = 1'b1;
        if (!wr_empty) begin
          wr_pop       = 1'b1;
          ram_wdata    = wr_head.data;
          ram_wmask    = wr_head.mask;
          last_wdata_d = wr_head.data;
        end
        addr_d  = addr_q + 1'b1;
        beats_d = beats_q - 6'd1;
        if (beats_q == '0) state_d = ST_IDLE;
      end
      ST_RBURST: begin
        ram_re  = 1'b1;
        addr_d  = addr_q + 1'b1;
        beats_d = beats_q - 6'd1;
        if (beats_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!ram_wmask[b]) mem[addr_q][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    if (ram_re) ram_rdata_q <= mem[addr_q];
  end

  // Read data lands one cycle after the RAM access; a full FIFO drops the beat.
  mcb_sync_fifo #(.WIDTH(32), .DEPTH(MCB_DATA_DEPTH)) u_rd_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(rd_valid_q), .din_i(ram_rdata_q), .pop_i(rd_en),
    .dout_o(rd_data), .full_o(rd_full), .empty_o(rd_empty), .count_o(rd_count)
  );

`ifdef MCB_EMU_ERR_EN
  logic wr_underrun_q, wr_error_q, rd_overflow_q, rd_error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_underrun_q <= 1'b0;
      wr_error_q    <= 1'b0;
      rd_overflow_q <= 1'b0;
      rd_error_q    <= 1'b0;
    end else begin
      if (state_q == ST_WBURST && wr_empty) wr_underrun_q <= 1'b1;
      if (wr_en && wr_full)                 wr_error_q    <= 1'b1;
      if (rd_valid_q && rd_full)            rd_overflow_q <= 1'b1;
      if (rd_en && rd_empty)                rd_error_q    <= 1'b1;
    end
  end

  assign wr_underrun = wr_underrun_q;
  assign wr_error    = wr_error_q;
  assign rd_overflow = rd_overflow_q;
  assign rd_error    = rd_error_q;
`else
  assign wr_underrun = 1'b0;
  assign wr_error    = 1'b0;
  assign rd_overflow = 1'b0;
  assign rd_error    = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{cmd_count, cmd_head};

endmodule

// File: tb/tb_mcb_port_emu.sv
// Self-checking bench for mcb_port_emu: reference memory model plus a read scoreboard.
module tb_mcb_port_emu;
  import mcb_port_emu_pkg::*;

`ifdef MCB_EMU_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic        calib_done;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_empty, cmd_full;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full, wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun, wr_error;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full, rd_empty;
  logic [6:0]  rd_count;
  logic        rd_overflow, rd_error;

  mcb_port_emu #(.MEM_ADDR_W(8), .CALIB_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_empty(cmd_empty), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full), .wr_empty(wr_empty),
    .wr_count(wr_count), .wr_underrun(wr_underrun), .wr_error(wr_error),
    .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_count(rd_count), .rd_overflow(rd_overflow), .rd_error(rd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  m;
    logic [31:0] d;
  } wbeat_t;

  typedef struct {
    logic [31:0] d1;
    logic [3:0]  m1;
    logic [31:0] d2;
    logic [3:0]  m2;
    logic [29:0] addr;
    logic [31:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_mem [256];
  logic [31:0] last_wdata = '0;
  wbeat_t      wq[$];
  logic [31:0] sb[$];
  vec_t        vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Every task below starts and ends on a falling edge.
  task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b1; wr_data = d; wr_mask = m;
    wq.push_back('{m: m, d: d});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [5:0] bl);
    wbeat_t b;
    for (int i = 0; i <= int'(bl); i++) begin
      logic [7:0] w;
      w = a + 8'(i);
      if (wq.size() > 0) begin
        b = wq.pop_front();
        for (int k = 0; k < 4; k++)
          if (!b.m[k]) model_mem[w][8*k +: 8] = b.d[8*k +: 8];
        last_wdata = b.d;
      end else begin
        model_mem[w] = last_wdata;
      end
    end
  endtask

  task automatic expect_rd(input logic [7:0] a, input logic [5:0] bl);
    for (int i = 0; i <= int'(bl); i++) sb.push_back(model_mem[a + 8'(i)]);
  endtask

  task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
    int budget = 300;
    while (cmd_full && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (cmd_full) check("cmd_push_timeout", 32'(cmd_full), 32'd0);
    cmd_en = 1'b1; cmd_instr = instr; cmd_bl = bl; cmd_byte_addr = addr;
    @(negedge clk);
    cmd_en = 1'b0;
    if (!instr[2] && !instr[0]) model_write(addr[9:2], bl);
  endtask

  task automatic drain(input int n);
    int got = 0;
    int budget = 1000;
    while (got < n && budget > 0) begin
      if (!rd_empty) begin
        if (sb.size() == 0) check("scoreboard_empty", 32'(sb.size()), 32'd1);
        else check("rd_data", rd_data, sb.pop_front());
        rd_en = 1'b1;
        got++;
      end else begin
        rd_en = 1'b0;
      end
      @(negedge clk);
      budget--;
    end
    rd_en = 1'b0;
    if (got < n) check("drain_timeout", 32'(got), 32'(n));
  endtask

  task automatic wait_calib();
    int budget = 100;
    while (!calib_done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("calib_wait", 32'(calib_done), 32'd1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cmd_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    sb.delete(); wq.delete(); last_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'hAABBCCDD, 4'b0000, 32'h11223344, 4'b0101, 30'h010, 32'h11BB33DD};
    vecs[1] = '{32'h12345678, 4'b0000, 32'hFFFFFFFF, 4'b1111, 30'h104, 32'h12345678};
    vecs[2] = '{32'h00000000, 4'b0000, 32'hCAFEF00D, 4'b0000, 30'h208, 32'hCAFEF00D};
    vecs[3] = '{32'hDEADBEEF, 4'b0000, 32'h00000000, 4'b1010, 30'h30F, 32'hDE00BE00};
    vecs[4] = '{32'hA5A5A5A5, 4'b0000, 32'h5A5A5A5A, 4'b0011, 30'h3FC, 32'h5A5AA5A5};

    cmd_en = 0; cmd_instr = 0; cmd_bl = 0; cmd_byte_addr = 0;
    wr_en = 0; wr_mask = 0; wr_data = 0; rd_en = 0;
    rst_n = 1'b0;

    // Reset values and calibration timing.
    repeat (2) @(negedge clk);
    check("rst_calib_done", 32'(calib_done), 32'd0);
    check("rst_empties", {29'd0, cmd_empty, wr_empty, rd_empty}, 32'h7);
    check("rst_fulls", {29'd0, cmd_full, wr_full, rd_full}, 32'h0);
    check("rst_counts", {18'd0, wr_count, rd_count}, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_flags", {28'd0, wr_underrun, wr_error, rd_overflow, rd_error}, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check($sformatf("calib_cycle_%0d", i), 32'(calib_done), 32'(i == 16));
    end
    check("calib_cmd_empty", 32'(cmd_empty), 32'd1);
    check("calib_wr_count", 32'(wr_count), 32'd0);

    // Full 64-beat write then read, including write-FIFO overflow attempt.
    for (int i = 0; i < 64; i++) push_wr(32'(i), 4'h0);
    check("wr_count_64", 32'(wr_count), 32'd64);
    check("wr_full_64", 32'(wr_full), 32'd1);
    wr_en = 1'b1; wr_data = 32'hBAD0BAD0; wr_mask = 4'h0;
    @(negedge clk);
    wr_en = 1'b0;
    check("wr_count_push_full", 32'(wr_count), 32'd64);
    check("wr_error", 32'(wr_error), 32'(ERR_EN));
    push_cmd(INSTR_WRITE, 6'(MCB_MAX_BL), 30'h0);
    push_cmd(INSTR_READ, 6'(MCB_MAX_BL), 30'h0);
    expect_rd(8'h00, 6'(MCB_MAX_BL));
    begin
      int budget = 300;
      while (rd_count != 7'd64 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
    end
    check("rd_count_64", 32'(rd_count), 32'd64);
    check("rd_full_64", 32'(rd_full), 32'd1);
    check("rd_overflow_none", 32'(rd_overflow), 32'd0);
    drain(64);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("rd_error", 32'(rd_error), 32'(ERR_EN));
    check("rd_empty_after_pop_empty", 32'(rd_empty), 32'd1);

    // Byte-mask table.
    for (int v = 0; v < 5; v++) begin
      push_wr(vecs[v].d1, vecs[v].m1);
      push_cmd(INSTR_WRITE, 6'd0, vecs[v].addr);
      push_wr(vecs[v].d2, vecs[v].m2);
      push_cmd(INSTR_WRITE_AP, 6'd0, vecs[v].addr);
      push_cmd(INSTR_READ_AP, 6'd0, vecs[v].addr);
      sb.push_back(vecs[v].exp);
      drain(1);
    end

    // Commands queue while uncalibrated; the fifth push is lost.
    apply_reset();
    check("flags_cleared", {28'd0, wr_underrun, wr_error, rd_overflow, rd_error}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cmd_en = 1'b1; cmd_instr = INSTR_READ; cmd_bl = 6'd0; cmd_byte_addr = 30'((5 + i) * 4);
      @(negedge clk);
      check($sformatf("cmd_full_push_%0d", i + 1), 32'(cmd_full), 32'(i >= 3));
      if (i < 4) expect_rd(8'(5 + i), 6'd0);
    end
    cmd_en = 1'b0;
    check("held_uncalibrated", 32'(calib_done), 32'd0);
    drain(4);
    repeat (30) @(negedge clk);
    check("fifth_cmd_lost", 32'(rd_empty), 32'd1);
    check("cmd_empty_after", 32'(cmd_empty), 32'd1);

    // Address wrap across the top of RAM, then an interleaved refresh.
    for (int i = 0; i < 4; i++) push_wr($urandom, 4'h0);
    push_cmd(INSTR_WRITE, 6'd3, 30'(254 * 4));
    push_cmd(INSTR_REFRESH, 6'd0, 30'h0);
    push_cmd(INSTR_READ, 6'd3, 30'(254 * 4));
    expect_rd(8'd254, 6'd3);
    drain(4);

    // Write underrun.
    push_wr(32'h0D0D0001, 4'h0);
    push_wr(32'h0D0D0002, 4'h0);
    push_cmd(INSTR_WRITE, 6'd3, 30'h100);
    repeat (10) @(negedge clk);
    check("wr_underrun", 32'(wr_underrun), 32'(ERR_EN));
    push_cmd(INSTR_READ, 6'd3, 30'h100);
    expect_rd(8'd64, 6'd3);
    drain(4);

    // Reset in the middle of a read burst.
    push_cmd(INSTR_READ, 6'd63, 30'h0);
    begin
      int budget = 20;
      while (rd_empty && budget > 0) begin
        @(negedge clk);
        budget--;
      end
    end
    check("midburst_rd_started", 32'(rd_empty), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_empties", {29'd0, cmd_empty, wr_empty, rd_empty}, 32'h7);
    check("midrst_rd_count", 32'(rd_count), 32'd0);
    apply_reset();
    wait_calib();
    push_cmd(INSTR_READ, 6'd3, 30'h100);
    expect_rd(8'd64, 6'd3);
    drain(4);
    repeat (10) @(negedge clk);
    check("end_rd_empty", 32'(rd_empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
